// File: rtl/truxton2_gfx_arbiter.sv
`default_nettype none
// truxton2_gfx_arbiter: shares one SDRAM bank read port among four GP9001 fetch clients,
// round-robin, assembling two 16-bit bank words per 32-bit fetch into a per-client cache entry.
module truxton2_gfx_arbiter #(
    parameter int AW   = 22,
    parameter int NCLI = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic [NCLI-1:0]      cli_cs_i,
    input  logic [NCLI*AW-1:0]   cli_addr_i,
    output logic [NCLI-1:0]      cli_ok_o,
    output logic [NCLI*32-1:0]   cli_dout_o,
    output logic [AW-1:0]        ba_addr_o,
    output logic                 ba_rd_o,
    input  logic                 ba_ack_i,
    input  logic                 ba_dok_i,
    input  logic [15:0]          data_read_i
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [1:0]      ptr_q, gnt_q;
    logic [AW-2:0]   addr_q;
    logic            discard_q;
    logic            wcnt_q;
    logic [15:0]     lo_q;
    logic [NCLI-1:0] valid_q;
    logic [NCLI-1:0] ok_q;
    logic [AW-2:0]   tag_q  [NCLI];
    logic [31:0]     data_q [NCLI];

    logic [AW-2:0]   w_cli_tag [NCLI];
    logic [NCLI-1:0] w_addr_lsb;
    logic [NCLI-1:0] w_hit;
    logic [NCLI-1:0] w_elig;
    logic            w_any;
    logic [1:0]      w_gidx;
    logic [1:0]      w_idx;
    logic            w_fill;
    logic            w_unused_lsb;

    generate
        for (genvar i = 0; i < NCLI; i++) begin : g_cli
            assign w_cli_tag[i]  = cli_addr_i[i*AW+1 +: AW-1];
            assign w_addr_lsb[i] = cli_addr_i[i*AW];
            assign w_hit[i]      = cli_cs_i[i] & valid_q[i] & (tag_q[i] == w_cli_tag[i]);
            assign w_elig[i]     = cli_cs_i[i] & ~w_hit[i];
            assign cli_dout_o[i*32 +: 32] = data_q[i];
        end
    endgenerate

    // Fetches are 32-bit aligned, so the low address bit never reaches the cache or bank.
    assign w_unused_lsb = ^w_addr_lsb;

    // Round-robin search starting one past the last granted client.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = ptr_q;
        w_idx  = ptr_q;
        for (int k = 1; k <= NCLI; k++) begin
            w_idx = ptr_q + 2'(k);
            if (!w_any && w_elig[w_idx]) begin
                w_any  = 1'b1;
                w_gidx = w_idx;
            end
        end
    end

    assign w_fill = (state_q == S_DATA) & ba_dok_i & wcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_any) state_d = S_REQ;
            S_REQ:   if (ba_ack_i) state_d = S_DATA;
            S_DATA:  if (ba_dok_i && wcnt_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ba_rd_o   = (state_q == S_REQ);
        ba_addr_o = {addr_q, 1'b0};
        cli_ok_o  = ok_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= 2'd3;
            gnt_q     <= 2'd0;
            addr_q    <= '0;
            discard_q <= 1'b0;
            wcnt_q    <= 1'b0;
            lo_q      <= '0;
            valid_q   <= '0;
            ok_q      <= '0;
            for (int i = 0; i < NCLI; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            ok_q <= w_hit;
            if (state_q == S_IDLE && w_any) begin
                gnt_q     <= w_gidx;
                ptr_q     <= w_gidx;
                addr_q    <= w_cli_tag[w_gidx];
                discard_q <= 1'b0;
            end
            // A flush during a bank transaction lets it finish but forbids the valid bit.
            if (flush_i && state_q != S_IDLE) begin
                discard_q <= 1'b1;
            end
            if (state_q == S_DATA && ba_dok_i) begin
                wcnt_q <= ~wcnt_q;
                if (!wcnt_q) begin
                    lo_q <= data_read_i;
                end
            end
            if (w_fill) begin
                tag_q[gnt_q]  <= addr_q;
                data_q[gnt_q] <= {data_read_i, lo_q};
            end
            if (flush_i) begin
                valid_q <= '0;
            end else if (w_fill && !discard_q) begin
                valid_q[gnt_q] <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire
